// File: rtl/trb_in_demux.sv
// Frame distributor: hands each fixed-length LLR frame from one input stream to
// the next decoder lane that has room for a whole frame, resyncing on bad framing.
module trb_in_demux #(
  parameter int NUM_TURBO = 16,
  parameter int FRAME_LEN = 3084,
  parameter int CNT_W     = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           st_data_in,
  input  logic                 st_valid_in,
  input  logic                 st_sop_in,
  input  logic                 st_eop_in,
  output logic                 st_ready_out,
  input  logic [NUM_TURBO-1:0] st_ready_in,
  output logic [7:0]           st_data_out,
  output logic [NUM_TURBO-1:0] st_valid_out,
  output logic [NUM_TURBO-1:0] st_sop_out,
  output logic [NUM_TURBO-1:0] st_eop_out,
  output logic [3:0]           lane_sel,
  output logic                 err_sop,
  output logic                 err_len
);

  // state   | meaning
  // S_GRANT | probing lane r_ptr for room, one lane per cycle, input stalled
  // S_FWD   | streaming the current frame to lane r_sel (cnt==0: hunting sop)
  // S_DROP  | frame overran FRAME_LEN; discarding beats up to its eop
  typedef enum logic [1:0] {
    S_GRANT = 2'd0,
    S_FWD   = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  localparam logic [3:0]       LAST_LANE = 4'(NUM_TURBO - 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);

  state_t               r_state;
  logic [3:0]           r_ptr;
  logic [3:0]           r_sel;
  logic [CNT_W-1:0]     r_cnt;

  logic                 w_accept;
  logic [3:0]           w_ptr_nxt;
  logic [3:0]           w_sel_nxt;
  logic [NUM_TURBO-1:0] w_lane_hot;

  assign st_ready_out = (r_state != S_GRANT);
  assign w_accept     = st_valid_in & st_ready_out;
  assign w_ptr_nxt    = (r_ptr == LAST_LANE) ? 4'd0 : r_ptr + 4'd1;
  assign w_sel_nxt    = (r_sel == LAST_LANE) ? 4'd0 : r_sel + 4'd1;
  assign w_lane_hot   = NUM_TURBO'(1) << r_sel;
  assign lane_sel     = (r_state == S_FWD) ? r_sel : r_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_GRANT;
      r_ptr        <= 4'd0;
      r_sel        <= 4'd0;
      r_cnt        <= '0;
      st_data_out  <= 8'd0;
      st_valid_out <= '0;
      st_sop_out   <= '0;
      st_eop_out   <= '0;
      err_sop      <= 1'b0;
      err_len      <= 1'b0;
    end else begin
      st_valid_out <= '0;
      st_sop_out   <= '0;
      st_eop_out   <= '0;
      err_sop      <= 1'b0;
      err_len      <= 1'b0;

      case (r_state)
        S_GRANT: begin
          if (st_ready_in[r_ptr]) begin
            r_sel   <= r_ptr;
            r_cnt   <= '0;
            r_state <= S_FWD;
          end else begin
            r_ptr <= w_ptr_nxt;
          end
        end

        S_FWD: begin
          if (w_accept) begin
            if (r_cnt == '0) begin
              if (!st_sop_in) begin
                err_sop <= 1'b1;
              end else begin
                st_data_out  <= st_data_in;
                st_valid_out <= w_lane_hot;
                st_sop_out   <= w_lane_hot;
                // sop and eop on one beat can never be a full frame here
                if (st_eop_in) begin
                  st_eop_out <= w_lane_hot;
                  err_len    <= 1'b1;
                  r_ptr      <= w_sel_nxt;
                  r_state    <= S_GRANT;
                end else begin
                  r_cnt <= CNT_W'(1);
                end
              end
            end else begin
              st_data_out  <= st_data_in;
              st_valid_out <= w_lane_hot;
              if (st_sop_in) begin
                err_sop <= 1'b1;
              end
              if (r_cnt == LAST_BEAT) begin
                st_eop_out <= w_lane_hot;
                r_ptr      <= w_sel_nxt;
                if (st_eop_in) begin
                  r_state <= S_GRANT;
                end else begin
                  err_len <= 1'b1;
                  r_state <= S_DROP;
                end
              end else if (st_eop_in) begin
                st_eop_out <= w_lane_hot;
                err_len    <= 1'b1;
                r_ptr      <= w_sel_nxt;
                r_state    <= S_GRANT;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end
        end

        S_DROP: begin
          if (w_accept && st_eop_in) begin
            r_state <= S_GRANT;
          end
        end

        default: begin
          r_state <= S_GRANT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trb_in_demux.sv
// Randomised scoreboard bench for trb_in_demux: a frame-level model predicts
// each forwarded beat and the error pulse totals; a monitor checks the lanes.
module tb_trb_in_demux;

  localparam int NT = 16;
  localparam int FL = 3084;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    st_data_in;
  logic          st_valid_in;
  logic          st_sop_in;
  logic          st_eop_in;
  logic          st_ready_out;
  logic [NT-1:0] st_ready_in;
  logic [7:0]    st_data_out;
  logic [NT-1:0] st_valid_out;
  logic [NT-1:0] st_sop_out;
  logic [NT-1:0] st_eop_out;
  logic [3:0]    lane_sel;
  logic          err_sop;
  logic          err_len;

  trb_in_demux #(.NUM_TURBO(NT), .FRAME_LEN(FL), .CNT_W(12)) dut (
    .clk          (clk),
    .rst          (rst),
    .st_data_in   (st_data_in),
    .st_valid_in  (st_valid_in),
    .st_sop_in    (st_sop_in),
    .st_eop_in    (st_eop_in),
    .st_ready_out (st_ready_out),
    .st_ready_in  (st_ready_in),
    .st_data_out  (st_data_out),
    .st_valid_out (st_valid_out),
    .st_sop_out   (st_sop_out),
    .st_eop_out   (st_eop_out),
    .lane_sel     (lane_sel),
    .err_sop      (err_sop),
    .err_len      (err_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       lane;
    logic [7:0] data;
    bit       sop;
    bit       eop;
  } beat_t;

  beat_t         exp_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            m_ptr = 0;
  logic [NT-1:0] cur_ready;
  int            exp_err_sop = 0;
  int            exp_err_len = 0;
  int            got_err_sop = 0;
  int            got_err_len = 0;
  int            m_lane_cnt[NT];
  int            g_lane_cnt[NT];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // the lane a new frame lands on: first lane with room, searching up from ptr
  function automatic int pick_lane();
    for (int k = 0; k < NT; k++) begin
      int l;
      l = (m_ptr + k) % NT;
      if (cur_ready[l]) return l;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    if (err_sop) got_err_sop++;
    if (err_len) got_err_len++;
    if (st_valid_out != '0) begin
      int    lane;
      beat_t e;
      lane = -1;
      for (int i = 0; i < NT; i++) if (st_valid_out[i]) lane = i;
      chk("valid_onehot", 64'($onehot(st_valid_out)), 64'd1);
      chk("sop_eop_within_valid", 64'((st_sop_out | st_eop_out) & ~st_valid_out), 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 64'(lane), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        if (lane >= 0) g_lane_cnt[lane]++;
        chk("beat",
            {32'(lane), st_data_out, 7'd0, st_sop_out[lane], 7'd0, st_eop_out[lane]},
            {32'(e.lane), e.data, 7'd0, e.sop, 7'd0, e.eop});
      end
    end else begin
      chk("idle_strobes", 64'(st_sop_out | st_eop_out), 64'd0);
    end
  end

  task automatic do_reset(input logic [NT-1:0] rdy);
    rst         = 1'b1;
    st_valid_in = 1'b0;
    st_sop_in   = 1'b0;
    st_eop_in   = 1'b0;
    st_ready_in = rdy;
    cur_ready   = rdy;
    m_ptr       = 0;
    @(posedge clk); #1;
    chk("reset_outputs",
        {st_data_out, st_valid_out, st_sop_out, st_eop_out, lane_sel, err_sop, err_len, st_ready_out},
        64'd0);
    rst = 1'b0;
  endtask

  task automatic send_frame(input int j, input int l, input int msop, input logic [NT-1:0] new_rdy,
                            input int gap_pct, input int abort_at, output int first_wait);
    int    lane;
    int    b;
    int    waits;
    beat_t bt;
    lane       = pick_lane();
    first_wait = 0;
    for (int i = 0; i < j + l; i++) begin
      if (i == abort_at) begin
        st_valid_in = 1'b0;
        return;
      end
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        st_valid_in = 1'b0;
        @(posedge clk); #1;
      end
      b           = i - j;
      st_data_in  = 8'($urandom);
      st_sop_in   = (b == 0) || (msop > 0 && b == msop);
      st_eop_in   = (b == l - 1);
      st_valid_in = 1'b1;
      waits = 0;
      @(negedge clk);
      while (!st_ready_out && waits < 200) begin
        waits++;
        @(negedge clk);
      end
      if (!st_ready_out) begin
        n_checks++;
        n_errors++;
        $display("FAIL handshake_timeout: beat %0d not accepted within 200 cycles", i);
        st_valid_in = 1'b0;
        return;
      end
      if (i == 0) first_wait = waits;
      if (b < 0) begin
        exp_err_sop++;
      end else if (b < FL) begin
        bt.lane = lane;
        bt.data = st_data_in;
        bt.sop  = (b == 0);
        bt.eop  = (b == l - 1) || (b == FL - 1);
        exp_q.push_back(bt);
        m_lane_cnt[lane]++;
        if (b > 0 && st_sop_in) exp_err_sop++;
        if (bt.eop && l != FL) exp_err_len++;
        if (bt.eop) m_ptr = (lane + 1) % NT;
        if (b == 0 && l > 1) begin
          cur_ready   = new_rdy;
          st_ready_in = new_rdy;
        end
      end
      @(posedge clk); #1;
    end
    st_valid_in = 1'b0;
    st_sop_in   = 1'b0;
    st_eop_in   = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    @(negedge clk);
    chk({name, "_pending_beats"}, 64'(exp_q.size()), 64'd0);
    chk({name, "_err_sop_count"}, 64'(got_err_sop), 64'(exp_err_sop));
    chk({name, "_err_len_count"}, 64'(got_err_len), 64'(exp_err_len));
    for (int i = 0; i < NT; i++)
      chk($sformatf("%s_lane%0d_beats", name, i), 64'(g_lane_cnt[i]), 64'(m_lane_cnt[i]));
    @(posedge clk); #1;
  endtask

  initial begin
    int w;
    for (int i = 0; i < NT; i++) begin
      m_lane_cnt[i] = 0;
      g_lane_cnt[i] = 0;
    end
    rst         = 1'b1;
    st_data_in  = 8'd0;
    st_valid_in = 1'b0;
    st_sop_in   = 1'b0;
    st_eop_in   = 1'b0;
    st_ready_in = '1;
    cur_ready   = '1;
    repeat (3) @(posedge clk);
    #1;

    do_reset('1);
    repeat (3) send_frame(0, FL, -1, '1, 0, -1, w);
    drain("t1");

    do_reset(16'h0004);
    send_frame(0, FL, -1, '1, 0, -1, w);
    chk("t2_grant_cycles", 64'(w), 64'd3);
    send_frame(0, 40, -1, '1, 0, -1, w);
    drain("t2");

    do_reset('1);
    send_frame(2, FL, -1, '1, 0, -1, w);
    drain("t3");

    do_reset('1);
    send_frame(0, 100, -1, '1, 0, -1, w);
    send_frame(0, 30, -1, '1, 0, -1, w);
    drain("t4");

    do_reset('1);
    send_frame(0, FL + 6, -1, '1, 0, -1, w);
    send_frame(0, 10, -1, '1, 0, -1, w);
    drain("t5");

    do_reset('1);
    send_frame(0, FL, -1, '1, 0, 500, w);
    do_reset('1);
    send_frame(0, FL, -1, '1, 0, -1, w);
    send_frame(0, 1, -1, '1, 0, -1, w);
    drain("t6");

    do_reset(NT'($urandom_range(1, 65535)));
    for (int f = 0; f < 8; f++) begin
      int kind;
      int l;
      int j;
      int ms;
      int lim;
      kind = $urandom_range(0, 3);
      case (kind)
        0:       l = $urandom_range(1, 60);
        1:       l = FL;
        2:       l = FL + $urandom_range(1, 8);
        default: l = FL - 1;
      endcase
      j   = $urandom_range(0, 2);
      lim = (l < FL) ? l : FL;
      ms  = (lim >= 4 && $urandom_range(0, 1) == 1) ? $urandom_range(1, lim - 2) : -1;
      send_frame(j, l, ms, NT'($urandom_range(1, 65535)), 10, -1, w);
    end
    drain("rand");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
